// File: rtl/gpc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gpc_ctrl_pkg
// Shared types and constants for the gpc3031_5 accumulate controller.
//   state_t        : frame sequencer states
//   GPC3031_MAX    : largest value one gpc3031_5 beat can produce
//   GPC3031_DST_W  : width of the gpc3031_5 result
//   acc_w_min()    : smallest accumulator width that holds a full frame sum
// -----------------------------------------------------------------------------
package gpc_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int GPC3031_MAX   = 31;
   localparam int GPC3031_DST_W = 5;

   // Bits needed to hold beats * GPC3031_MAX without overflow.
   function automatic int acc_w_min(input int beats);
      return $clog2(GPC3031_MAX * beats + 1);
   endfunction

endpackage

// File: rtl/gpc3031_5.sv
// -----------------------------------------------------------------------------
// gpc3031_5
// Generalised parallel counter: one weight-1 bit, three weight-2 bits and
// three weight-8 bits compressed into a 5-bit binary value (0..31).
// Ports:
//   src0 [0]   weight-1 bit
//   src1 [2:0] weight-2 bits
//   src3 [2:0] weight-8 bits
//   dst  [4:0] src0 + 2*popcount(src1) + 8*popcount(src3)
// -----------------------------------------------------------------------------
module gpc3031_5
   import gpc_ctrl_pkg::*;
(
   input  logic                     src0,
   input  logic [2:0]               src1,
   input  logic [2:0]               src3,
   output logic [GPC3031_DST_W-1:0] dst
);

   logic sum1_s;
   logic car1_s;
   logic sum3_s;
   logic car3_s;

   // One full adder per column; the columns never overlap, so no carry chain.
   always_comb begin
      sum1_s = src1[0] ^ src1[1] ^ src1[2];
      car1_s = (src1[0] & src1[1]) | (src1[0] & src1[2]) | (src1[1] & src1[2]);
      sum3_s = src3[0] ^ src3[1] ^ src3[2];
      car3_s = (src3[0] & src3[1]) | (src3[0] & src3[2]) | (src3[1] & src3[2]);
      dst    = {car3_s, sum3_s, car1_s, sum1_s, src0};
   end

endmodule

// File: rtl/gpc3031_5_accum_ctrl.sv
// -----------------------------------------------------------------------------
// gpc3031_5_accum_ctrl
// Frame sequencer time-sharing one gpc3031_5 across a beat stream. BEATS
// accepted beats are compressed and summed; the frame sum is then offered on
// a valid/ready output. Frames never overlap.
// Parameters:
//   BEATS  beats per frame (>= 1)
//   ACC_W  accumulator / out_sum width (>= acc_w_min(BEATS))
// Ports:
//   clk, rst              clock (rising), asynchronous active-high reset
//   in_valid / in_ready   beat handshake
//   in_src0/1/3           weight-1 / weight-2 / weight-8 bits of a beat
//   out_valid / out_ready frame sum handshake
//   out_sum               registered frame sum, stable while stalled
//   busy                  high whenever the sequencer is not IDLE
// Build option:
//   GPC_PIPE_EN  adds a register stage between gpc3031_5 and the adder; the
//                final beat is then summed in a one-cycle DRAIN state.
// -----------------------------------------------------------------------------
module gpc3031_5_accum_ctrl
   import gpc_ctrl_pkg::*;
#(
   parameter int BEATS = 8,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_src0,
   input  logic [2:0]       in_src1,
   input  logic [2:0]       in_src3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             busy
);

   localparam int CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

`ifdef GPC_PIPE_EN
   localparam state_t FINAL_ST = DRAIN;
`else
   localparam state_t FINAL_ST = DONE;
`endif

   generate
      if (BEATS < 1) begin : g_bad_beats
         $error("gpc3031_5_accum_ctrl: BEATS must be at least 1");
      end
      if (ACC_W < acc_w_min(BEATS)) begin : g_bad_acc_w
         $error("gpc3031_5_accum_ctrl: ACC_W too narrow for BEATS*31");
      end
   endgenerate

   state_t                   state_r;
   state_t                   state_nx_s;
   logic [ACC_W-1:0]         acc_r;
   logic [ACC_W-1:0]         acc_nx_s;
   logic [CNT_W-1:0]         cnt_r;
   logic [CNT_W-1:0]         cnt_nx_s;
   logic [ACC_W-1:0]         sum_nx_s;
   logic [ACC_W-1:0]         out_sum_r;
   logic                     in_ready_r;
   logic                     out_valid_r;
   logic                     busy_r;
   logic                     accept_s;
   logic                     last_s;
   logic [GPC3031_DST_W-1:0] dst_s;
   logic [ACC_W-1:0]         add_s;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_sum   = out_sum_r;
   assign busy      = busy_r;

   assign accept_s  = in_valid & in_ready_r;
   assign last_s    = (cnt_r == LAST_CNT);

   gpc3031_5 u_gpc (
      .src0 (in_src0),
      .src1 (in_src1),
      .src3 (in_src3),
      .dst  (dst_s)
   );

`ifdef GPC_PIPE_EN
   logic [GPC3031_DST_W-1:0] pipe_dst_r;
   logic                     pipe_vld_r;

   // Pipe stage: holds the compressed beat plus a tag saying it was accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_dst_r <= {GPC3031_DST_W{1'b0}};
         pipe_vld_r <= 1'b0;
      end else begin
         pipe_dst_r <= dst_s;
         pipe_vld_r <= accept_s;
      end
   end

   assign add_s = pipe_vld_r ? ACC_W'(pipe_dst_r) : {ACC_W{1'b0}};
`else
   assign add_s = accept_s ? ACC_W'(dst_s) : {ACC_W{1'b0}};
`endif

   // Next-state, accumulator and beat-count logic.
   always_comb begin
      state_nx_s = state_r;
      acc_nx_s   = acc_r;
      cnt_nx_s   = cnt_r;
      sum_nx_s   = out_sum_r;

      case (state_r)
         IDLE: begin
            // acc is always zero here, so loading add_s equals acc = dst.
            acc_nx_s = add_s;
            if (accept_s) begin
               cnt_nx_s = CNT_W'(1);
               if (BEATS == 1) begin
                  state_nx_s = FINAL_ST;
               end else begin
                  state_nx_s = ACCUM;
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ACCUM: begin
            // With the pipe, the previous beat lands here even in a gap.
            acc_nx_s = acc_r + add_s;
            if (accept_s) begin
               cnt_nx_s = cnt_r + CNT_W'(1);
               if (last_s) begin
                  state_nx_s = FINAL_ST;
               end else begin
                  state_nx_s = ACCUM;
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
`ifdef GPC_PIPE_EN
         DRAIN: begin
            acc_nx_s   = acc_r + add_s;
            state_nx_s = DONE;
         end
`endif
         DONE: begin
            if (out_ready) begin
               acc_nx_s   = {ACC_W{1'b0}};
               cnt_nx_s   = {CNT_W{1'b0}};
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            acc_nx_s   = {ACC_W{1'b0}};
            cnt_nx_s   = {CNT_W{1'b0}};
            state_nx_s = IDLE;
         end
      endcase

      // Capture the completed sum once, on entry to DONE.
      if ((state_nx_s == DONE) && (state_r != DONE)) begin
         sum_nx_s = acc_nx_s;
      end else begin
         sum_nx_s = out_sum_r;
      end
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_r       <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         out_sum_r   <= {ACC_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         acc_r       <= acc_nx_s;
         cnt_r       <= cnt_nx_s;
         out_sum_r   <= sum_nx_s;
         in_ready_r  <= (state_nx_s == IDLE) || (state_nx_s == ACCUM);
         out_valid_r <= (state_nx_s == DONE);
         busy_r      <= (state_nx_s != IDLE);
      end
   end

endmodule

// File: tb/tb_gpc3031_5_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpc3031_5_accum_ctrl
// Directed and randomized checks of the frame accumulator, with a BEATS=4
// instance and a BEATS=1 instance sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_gpc3031_5_accum_ctrl;

`ifdef GPC_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       v4 = 1'b0, s0_4 = 1'b0, or4 = 1'b0;
   logic [2:0] s1_4 = 3'd0, s3_4 = 3'd0;
   logic       ir4, ov4, busy4;
   logic [7:0] sum4;

   logic       v1 = 1'b0, s0_1 = 1'b0, or1 = 1'b0;
   logic [2:0] s1_1 = 3'd0, s3_1 = 3'd0;
   logic       ir1, ov1, busy1;
   logic [7:0] sum1;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   gpc3031_5_accum_ctrl #(.BEATS(4), .ACC_W(8)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_src0(s0_4),
      .in_src1(s1_4), .in_src3(s3_4), .out_valid(ov4), .out_ready(or4),
      .out_sum(sum4), .busy(busy4));

   gpc3031_5_accum_ctrl #(.BEATS(1), .ACC_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_src0(s0_1),
      .in_src1(s1_1), .in_src3(s3_1), .out_valid(ov1), .out_ready(or1),
      .out_sum(sum1), .busy(busy1));

   // Reference: weighted bit count of one beat.
   function automatic int beat_val(input logic s0, input logic [2:0] s1, input logic [2:0] s3);
      int v;
      v = (s0 === 1'b1) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         if (s1[i] === 1'b1) v = v + 2;
         if (s3[i] === 1'b1) v = v + 8;
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat to the BEATS=4 instance for exactly one edge.
   task automatic send4(input logic s0, input logic [2:0] s1, input logic [2:0] s3);
      chk("b4_in_ready", 32'(ir4), 32'd1);
      v4 = 1'b1; s0_4 = s0; s1_4 = s1; s3_4 = s3;
      tick();
      v4 = 1'b0;
   endtask

   // After the last beat edge: out_valid must rise after exactly LAT edges.
   task automatic expect_frame4(input string tag, input int exp_sum);
      for (int i = 1; i < LAT; i++) begin
         chk({tag, "_early"}, 32'(ov4), 32'd0);
         tick();
      end
      chk({tag, "_ov"}, 32'(ov4), 32'd1);
      chk({tag, "_sum"}, 32'(sum4), 32'(exp_sum));
      chk({tag, "_ir"}, 32'(ir4), 32'd0);
   endtask

   task automatic handshake4(input string tag);
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      chk({tag, "_ov_clr"}, 32'(ov4), 32'd0);
      chk({tag, "_ir_set"}, 32'(ir4), 32'd1);
      chk({tag, "_idle"}, 32'(busy4), 32'd0);
   endtask

   initial begin : stim
      int exp_sum;
      int bv;
      logic [6:0] p;
      logic [2:0] r1, r3;
      logic r0;

      // Reset state
      #12;
      chk("rst_ir", 32'(ir4), 32'd1);
      chk("rst_ov", 32'(ov4), 32'd0);
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_sum", 32'(sum4), 32'd0);
      chk("rst1_ov", 32'(ov1), 32'd0);
      rst = 1'b0;
      tick();

      // 1: four all-ones beats back to back
      exp_sum = 0;
      for (int i = 0; i < 4; i++) begin
         send4(1'b1, 3'b111, 3'b111);
         exp_sum += beat_val(1'b1, 3'b111, 3'b111);
         if (i == 0) chk("t1_busy", 32'(busy4), 32'd1);
         if (i < 3) chk("t1_not_done", 32'(ov4), 32'd0);
      end
      expect_frame4("t1", exp_sum);
      handshake4("t1");

      // 2: specific beats separated by one-cycle gaps
      exp_sum = 0;
      send4(1'b1, 3'b011, 3'b100); exp_sum += beat_val(1'b1, 3'b011, 3'b100); tick();
      send4(1'b0, 3'b111, 3'b000); exp_sum += beat_val(1'b0, 3'b111, 3'b000); tick();
      send4(1'b0, 3'b000, 3'b111); exp_sum += beat_val(1'b0, 3'b000, 3'b111); tick();
      chk("t2_gap_no_done", 32'(ov4), 32'd0);
      tick();
      chk("t2_gap_no_done2", 32'(ov4), 32'd0);
      send4(1'b1, 3'b000, 3'b000); exp_sum += beat_val(1'b1, 3'b000, 3'b000);
      expect_frame4("t2", exp_sum);

      // 3: stall three cycles with junk on the input, then handshake
      for (int i = 0; i < 3; i++) begin
         v4 = 1'b1; s0_4 = 1'b1; s1_4 = 3'b111; s3_4 = 3'b111;
         tick();
         chk("t3_ov_hold", 32'(ov4), 32'd1);
         chk("t3_sum_hold", 32'(sum4), 32'(exp_sum));
         chk("t3_ir_low", 32'(ir4), 32'd0);
      end
      v4 = 1'b0;
      handshake4("t3");

      // 4: asynchronous reset mid-frame
      send4(1'b1, 3'b111, 3'b111);
      send4(1'b1, 3'b111, 3'b111);
      #2 rst = 1'b1;
      #1;
      chk("t4_ov", 32'(ov4), 32'd0);
      chk("t4_busy", 32'(busy4), 32'd0);
      chk("t4_ir", 32'(ir4), 32'd1);
      #1 rst = 1'b0;
      tick();
      exp_sum = 0;
      for (int i = 0; i < 4; i++) begin
         send4(1'b1, 3'b000, 3'b000);
         exp_sum += beat_val(1'b1, 3'b000, 3'b000);
      end
      expect_frame4("t4", exp_sum);
      handshake4("t4");

      // 5/6: BEATS=1, every input pattern (includes 0 and 31)
      for (int k = 0; k < 128; k++) begin
         p = 7'(k);
         chk("b1_ir", 32'(ir1), 32'd1);
         v1 = 1'b1; s0_1 = p[0]; s1_1 = p[3:1]; s3_1 = p[6:4];
         tick();
         v1 = 1'b0;
         for (int i = 1; i < LAT; i++) tick();
         chk("b1_ov", 32'(ov1), 32'd1);
         chk("b1_sum", 32'(sum1), 32'(beat_val(p[0], p[3:1], p[6:4])));
         or1 = 1'b1;
         tick();
         or1 = 1'b0;
         chk("b1_ov_clr", 32'(ov1), 32'd0);
      end

      // Random frames with random gaps and output stalls
      for (int f = 0; f < 20; f++) begin
         exp_sum = 0;
         for (int b = 0; b < 4; b++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 3'($urandom_range(0, 7));
            r3 = 3'($urandom_range(0, 7));
            send4(r0, r1, r3);
            bv = beat_val(r0, r1, r3);
            exp_sum += bv;
            if (b < 3) begin
               for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            end
         end
         expect_frame4("rnd", exp_sum);
         for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
            v4 = 1'($urandom_range(0, 1)); s0_4 = 1'b1; s1_4 = 3'b101; s3_4 = 3'b010;
            tick();
            chk("rnd_stall_sum", 32'(sum4), 32'(exp_sum));
            chk("rnd_stall_ov", 32'(ov4), 32'd1);
         end
         v4 = 1'b0;
         handshake4("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
